alu: RTL and testbench



---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_divider.sv | 53 +++++
 rtl/alu.sv | 128 ++++++++++++
 tb/tb_alu.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU: operand width and function codes.
// Codes 0100/0101 only do work when ALU_MULDIV_EN is defined.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0100;
    localparam logic [3:0] ALU_DIV = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;
    localparam logic [3:0] ALU_MEM = 4'b1100;

endpackage

// File: rtl/alu_divider.sv
// Combinational signed restoring divider: divides magnitudes, then restores signs.
// Quotient truncates toward zero; the remainder takes the dividend's sign.
module alu_divider #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_err_o
);

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;

    assign a_neg = dividend_i[WIDTH-1];
    assign b_neg = divisor_i[WIDTH-1];
    assign a_mag = a_neg ? (~dividend_i + 1'b1) : dividend_i;
    assign b_mag = b_neg ? (~divisor_i + 1'b1) : divisor_i;

    // The most negative dividend has magnitude 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        rem = '0;
        quo = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            rem = {rem[WIDTH-1:0], a_mag[i]};
            if (rem >= {1'b0, b_mag}) begin
                rem    = rem - {1'b0, b_mag};
                quo[i] = 1'b1;
            end
        end
    end

    always_comb begin
        quotient_o  = (a_neg ^ b_neg) ? (~quo + 1'b1) : quo;
        remainder_o = a_neg ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
        div_err_o   = 1'b0;
        if (divisor_i == '0) begin
            quotient_o  = '1;
            remainder_o = dividend_i;
            div_err_o   = 1'b1;
        end else if (dividend_i == {1'b1, {(WIDTH-1){1'b0}}} && divisor_i == '1) begin
            quotient_o  = {1'b1, {(WIDTH-1){1'b0}}};
            remainder_o = '0;
            div_err_o   = 1'b1;
        end
    end

endmodule

// File: rtl/alu.sv
// EX-stage ALU: operation mux feeding registered result and O/N/Z flags (1-cycle latency).
// Define ALU_MULDIV_EN to build the multiplier and divider; otherwise MUL/DIV act as unsupported codes.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [3:0]         Function,
    output logic [2*WIDTH-1:0] Out,
    output logic               O,
    output logic               N,
    output logic               Z
);

    logic [2*WIDTH-1:0] out_d, out_q;
    logic               o_d, o_q;
    logic               n_d, n_q;
    logic               z_d, z_q;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;

    assign sum   = A + B;
    assign diff  = A - B;
    assign and_r = A & B;
    assign or_r  = A | B;

`ifdef ALU_MULDIV_EN
    logic signed [2*WIDTH-1:0] prod;
    logic        [WIDTH-1:0]   div_quo;
    logic        [WIDTH-1:0]   div_rem;
    logic                      div_err;

    assign prod = $signed(A) * $signed(B);

    alu_divider #(.WIDTH(WIDTH)) u_divider (
        .dividend_i  (A),
        .divisor_i   (B),
        .quotient_o  (div_quo),
        .remainder_o (div_rem),
        .div_err_o   (div_err)
    );
`endif

    // Unsupported codes fall through to the default: zero result with Z set.
    always_comb begin
        out_d = '0;
        o_d   = 1'b0;
        n_d   = 1'b0;
        z_d   = 1'b1;
        case (Function)
            ALU_ADD: begin
                out_d = {{WIDTH{sum[WIDTH-1]}}, sum};
                o_d   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
                n_d   = sum[WIDTH-1];
                z_d   = (sum == '0);
            end
            ALU_SUB: begin
                out_d = {{WIDTH{diff[WIDTH-1]}}, diff};
                o_d   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
                n_d   = diff[WIDTH-1];
                z_d   = (diff == '0);
            end
            ALU_AND: begin
                out_d = {{WIDTH{1'b0}}, and_r};
                n_d   = and_r[WIDTH-1];
                z_d   = (and_r == '0);
            end
            ALU_OR: begin
                out_d = {{WIDTH{1'b0}}, or_r};
                n_d   = or_r[WIDTH-1];
                z_d   = (or_r == '0);
            end
            ALU_MEM: begin
                out_d = {{WIDTH{1'b0}}, sum};
                n_d   = sum[WIDTH-1];
                z_d   = (sum == '0);
            end
`ifdef ALU_MULDIV_EN
            ALU_MUL: begin
                out_d = prod;
                // Representable in WIDTH signed bits only if the top WIDTH+1 bits agree.
                o_d   = !((&prod[2*WIDTH-1:WIDTH-1]) || (~|prod[2*WIDTH-1:WIDTH-1]));
                n_d   = prod[2*WIDTH-1];
                z_d   = (prod == '0);
            end
            ALU_DIV: begin
                out_d = {div_rem, div_quo};
                o_d   = div_err;
                n_d   = div_quo[WIDTH-1];
                z_d   = (div_quo == '0);
            end
`endif
            default: begin
                out_d = '0;
                o_d   = 1'b0;
                n_d   = 1'b0;
                z_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            o_q   <= 1'b0;
            n_q   <= 1'b0;
            z_q   <= 1'b0;
        end else begin
            out_q <= out_d;
            o_q   <= o_d;
            n_q   <= n_d;
            z_q   <= z_d;
        end
    end

    assign Out = out_q;
    assign O   = o_q;
    assign N   = n_q;
    assign Z   = z_q;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed vector table plus random vectors checked against an integer model.
// Expectations for MUL/DIV follow ALU_MULDIV_EN.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  Function;
    logic [31:0] Out;
    logic        O;
    logic        N;
    logic        Z;

`ifdef ALU_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .Function (Function),
        .Out      (Out),
        .O        (O),
        .N        (N),
        .Z        (Z)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  f;
        logic [31:0] out;
        logic        o;
        logic        n;
        logic        z;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [34:0] exp_q[$];
    string       name_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;

    task automatic add_vec(input logic r, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] f, input logic [31:0] out, input logic o,
                           input logic n, input logic z, input string name);
        vec_t t;
        t.rst = r; t.a = a; t.b = b; t.f = f;
        t.out = out; t.o = o; t.n = n; t.z = z; t.name = name;
        vecs.push_back(t);
    endtask

    // Independent reference using integer arithmetic.
    function automatic logic [34:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] f);
        int          sa, sb, r;
        logic [15:0] r16, q16, rm16;
        logic [31:0] out;
        logic        o, n, z;
        sa = $signed(a);
        sb = $signed(b);
        out = 32'h0; o = 1'b0; n = 1'b0; z = 1'b1;
        r16 = 16'h0; q16 = 16'h0; rm16 = 16'h0; r = 0;
        case (f)
            4'b0000, 4'b0001: begin
                r   = (f == 4'b0000) ? sa + sb : sa - sb;
                r16 = r[15:0];
                out = {{16{r16[15]}}, r16};
                o   = (r > 32767) || (r < -32768);
                n   = r16[15];
                z   = (r16 == 16'h0);
            end
            4'b1000, 4'b1001, 4'b1100: begin
                if (f == 4'b1000) r16 = a & b;
                else if (f == 4'b1001) r16 = a | b;
                else r16 = a + b;
                out = {16'h0, r16};
                n   = r16[15];
                z   = (r16 == 16'h0);
            end
`ifdef ALU_MULDIV_EN
            4'b0100: begin
                r   = sa * sb;
                out = r;
                o   = (r > 32767) || (r < -32768);
                n   = out[31];
                z   = (out == 32'h0);
            end
            4'b0101: begin
                if (sb == 0) begin
                    q16 = 16'hFFFF; rm16 = a; o = 1'b1;
                end else if (sa == -32768 && sb == -1) begin
                    q16 = 16'h8000; rm16 = 16'h0; o = 1'b1;
                end else begin
                    r = sa / sb; q16 = r[15:0];
                    r = sa % sb; rm16 = r[15:0];
                end
                out = {rm16, q16};
                n   = q16[15];
                z   = (q16 == 16'h0);
            end
`endif
            default: ;
        endcase
        return {out, o, n, z};
    endfunction

    // scoreboard
    task automatic check_pending();
        logic [34:0] e;
        string       nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            if ({Out, O, N, Z} !== e) begin
                n_fail++;
                $display("FAIL %s: got Out=%h O=%b N=%b Z=%b, expected Out=%h O=%b N=%b Z=%b",
                         nm, Out, O, N, Z, e[34:3], e[2], e[1], e[0]);
            end
        end
    endtask

    // driver: each negedge checks the previous cycle's result, then drives the next operation
    task automatic drive(input vec_t t);
        @(negedge clk);
        check_pending();
        rst      = t.rst;
        A        = t.a;
        B        = t.b;
        Function = t.f;
        exp_q.push_back({t.out, t.o, t.n, t.z});
        name_q.push_back(t.name);
    endtask

    initial begin
        logic [3:0]  codes[10];
        logic [15:0] edges[6];
        logic [34:0] m;
        vec_t        t;

        rst = 1'b1; A = 16'h0; B = 16'h0; Function = 4'h0;

        add_vec(1, 16'h1234, 16'h5678, 4'b0000, 32'h0, 0, 0, 0, "reset0");
        add_vec(1, 16'hFFFF, 16'h8000, 4'b0010, 32'h0, 0, 0, 0, "reset1");
        add_vec(0, 16'hFF00, 16'hFFFF, 4'b0000, 32'hFFFFFEFF, 0, 1, 0, "add_neg");
        add_vec(0, 16'h7FFF, 16'h0001, 4'b0000, 32'hFFFF8000, 1, 1, 0, "add_ovf");
        add_vec(0, 16'h0001, 16'hFFFF, 4'b0000, 32'h00000000, 0, 0, 1, "add_zero");
        add_vec(0, 16'hFF00, 16'hFFFF, 4'b0001, 32'hFFFFFF01, 0, 1, 0, "sub_neg");
        add_vec(0, 16'h8000, 16'h0001, 4'b0001, 32'h00007FFF, 1, 0, 0, "sub_ovf");
        add_vec(0, 16'hFFFF, 16'hB0B0, 4'b1000, 32'h0000B0B0, 0, 1, 0, "and");
        add_vec(0, 16'hFFFF, 16'hB0B0, 4'b1001, 32'h0000FFFF, 0, 1, 0, "or");
        add_vec(0, 16'h0F0F, 16'hF0F0, 4'b1000, 32'h00000000, 0, 0, 1, "and_zero");
        add_vec(0, 16'hFFFF, 16'hB0B0, 4'b0100, MULDIV ? 32'h00004F50 : 32'h0, 0, 0, !MULDIV, "mul");
        add_vec(0, 16'h0100, 16'h0100, 4'b0100, MULDIV ? 32'h00010000 : 32'h0, MULDIV, 0, !MULDIV, "mul_ovf");
        add_vec(0, 16'hFFFF, 16'hB0B0, 4'b0101, MULDIV ? 32'hFFFF0000 : 32'h0, 0, 0, 1, "div_zeroq");
        add_vec(0, 16'h1234, 16'h0000, 4'b0101, MULDIV ? 32'h1234FFFF : 32'h0, MULDIV, MULDIV, !MULDIV, "div_by0");
        add_vec(0, 16'h8000, 16'hFFFF, 4'b0101, MULDIV ? 32'h00008000 : 32'h0, MULDIV, MULDIV, !MULDIV, "div_min");
        add_vec(0, 16'hFFF9, 16'h0002, 4'b0101, MULDIV ? 32'hFFFFFFFD : 32'h0, 0, MULDIV, !MULDIV, "div_neg");
        add_vec(0, 16'h0000, 16'h0008, 4'b1100, 32'h00000008, 0, 0, 0, "mem");
        add_vec(0, 16'hFFFF, 16'h0002, 4'b1100, 32'h00000001, 0, 0, 0, "mem_wrap");
        add_vec(0, 16'h8000, 16'h0000, 4'b1100, 32'h00008000, 0, 1, 0, "mem_msb");
        add_vec(0, 16'h1234, 16'h4321, 4'b0010, 32'h0, 0, 0, 1, "unsup_0010");
        add_vec(0, 16'hFFFF, 16'hFFFF, 4'b1111, 32'h0, 0, 0, 1, "unsup_1111");
        add_vec(1, 16'hFFFF, 16'hFFFF, 4'b0000, 32'h0, 0, 0, 0, "reset_mid");
        add_vec(0, 16'h0002, 16'h0003, 4'b0000, 32'h00000005, 0, 0, 0, "add_after_rst");

        foreach (vecs[i]) drive(vecs[i]);

        codes = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b1000,
                  4'b1001, 4'b1100, 4'b0010, 4'b0110, 4'b1110};
        edges = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h00FF};
        for (int k = 0; k < 60; k++) begin
            t.rst = 1'b0;
            t.f   = codes[$urandom_range(0, 9)];
            t.a   = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom_range(0, 65535));
            t.b   = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom_range(0, 65535));
            m     = model(t.a, t.b, t.f);
            t.out = m[34:3]; t.o = m[2]; t.n = m[1]; t.z = m[0];
            t.name = $sformatf("rand%0d_f%b_%h_%h", k, t.f, t.a, t.b);
            drive(t);
        end

        @(negedge clk);
        check_pending();
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
